linear_layer_start_fifo_srl: RTL and testbench

- Control and storage wrapper for the start-token FIFO between a producer task and a downstream PE task in the Linear_Layer dataflow.
- Owns occupancy tracking, full/empty flags and read-address generation.
- Instantiates the shift-register storage primitive, which shifts on write and reads at an address.
- First-word-fall-through: the head entry is visible on if_dout whenever if_empty_n=1.

---
 rtl/linear_layer_start_fifo_srl_pkg.sv | 30 +++
 rtl/linear_layer_start_fifo_srl_shiftreg.sv | 59 +++++
 rtl/linear_layer_start_fifo_srl.sv | 144 ++++++++++++++
 tb/tb_linear_layer_start_fifo_srl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/linear_layer_start_fifo_srl_pkg.sv
// -----------------------------------------------------------------------------
// linear_layer_start_fifo_srl_pkg
//
// Purpose : Shared constants and elaboration helpers for the start-token FIFO
//           that sits between the producer task and the downstream PE task
//           in the Linear_Layer dataflow.
//
// Contents: EMPTY_N_RST / FULL_N_RST - values the status flags take in reset
//           occ_width()               - bits needed to count 0..depth
//           depth_fits()              - storage must be addressable with the
//                                       configured read-address width
// -----------------------------------------------------------------------------
package linear_layer_start_fifo_srl_pkg;

   // An empty FIFO has no token to offer and has room to accept one.
   localparam logic EMPTY_N_RST = 1'b0;
   localparam logic FULL_N_RST  = 1'b1;

   // Width of an occupancy counter that must represent 0..depth inclusive.
   function automatic int occ_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   // Every storage slot must be reachable by the read address, and a FIFO
   // needs at least one slot.
   function automatic bit depth_fits(input int depth, input int addr_width);
      return (depth >= 1) && (depth <= (1 << addr_width));
   endfunction

endpackage : linear_layer_start_fifo_srl_pkg

// File: rtl/linear_layer_start_fifo_srl_shiftreg.sv
// -----------------------------------------------------------------------------
// linear_layer_start_fifo_srl_shiftreg
//
// Purpose : Shift-register token storage. A write shifts din into slot 0 and
//           moves every older entry up one slot; the read side is a plain
//           address-indexed mux, so the oldest entry lives at the highest
//           occupied index. Contents are never reset: the controller only
//           exposes slots it knows to be valid.
//
// Ports   : clk  in   rising-edge clock
//           we   in   shift enable (one accepted write)
//           addr in   read address, 0..DEPTH-1
//           din  in   token to store
//           dout out  token at addr (combinational read)
// -----------------------------------------------------------------------------
module linear_layer_start_fifo_srl_shiftreg
   import linear_layer_start_fifo_srl_pkg::*;
#(
   parameter int DATA_WIDTH = 1,
   parameter int ADDR_WIDTH = 1,
   parameter int DEPTH      = 2
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [DEPTH];

   always_comb begin
      mem_d = mem_q;
      if (we) begin
         mem_d[0] = din;
         for (int i = 1; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i-1];
         end
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   // Decoded read mux; works for any DEPTH up to 2**ADDR_WIDTH without
   // needing the address width to match the slot count exactly.
   always_comb begin
      dout = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (addr == ADDR_WIDTH'(i)) begin
            dout = mem_q[i];
         end
      end
   end

endmodule : linear_layer_start_fifo_srl_shiftreg

// File: rtl/linear_layer_start_fifo_srl.sv
// -----------------------------------------------------------------------------
// linear_layer_start_fifo_srl
//
// Purpose : Control wrapper for the start-token FIFO. Tracks occupancy,
//           produces registered full/empty flags and a registered read
//           address, and drives the shift-register storage. First-word-fall-
//           through: while if_empty_n=1 the oldest token is on if_dout.
//
// Handshake: a write is accepted (push) on a rising edge where
//           if_write & if_write_ce & if_full_n are all 1; a read is accepted
//           (pop) where if_read & if_read_ce & if_empty_n are all 1. A request
//           made against a deasserted flag has no effect and must be held by
//           the requester. Flags are registered, so acceptance never depends
//           combinationally on the opposite side's request.
//
// Ports   : clk               in   rising-edge clock
//           reset             in   synchronous, active-high
//           if_write_ce       in   write-side clock enable
//           if_write          in   producer write request
//           if_din            in   producer token
//           if_full_n         out  1 = space available
//           if_read_ce        in   read-side clock enable
//           if_read           in   consumer pop request
//           if_dout           out  head token (valid while if_empty_n=1)
//           if_empty_n        out  1 = token available
//           if_num_data_valid out  occupancy 0..DEPTH
// -----------------------------------------------------------------------------
module linear_layer_start_fifo_srl
   import linear_layer_start_fifo_srl_pkg::*;
#(
   parameter int DATA_WIDTH = 1,
   parameter int ADDR_WIDTH = 1,
   parameter int DEPTH      = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  if_write_ce,
   input  logic                  if_write,
   input  logic [DATA_WIDTH-1:0] if_din,
   output logic                  if_full_n,
   input  logic                  if_read_ce,
   input  logic                  if_read,
   output logic [DATA_WIDTH-1:0] if_dout,
   output logic                  if_empty_n,
   output logic [ADDR_WIDTH:0]   if_num_data_valid
);

   // ---------------------------------------------------------------------
   // Elaboration checks
   // ---------------------------------------------------------------------
   if (!depth_fits(DEPTH, ADDR_WIDTH)) begin : g_bad_depth
      $error("linear_layer_start_fifo_srl: DEPTH must be 1..2**ADDR_WIDTH");
   end

   // Follows from the check above, but keeps the occupancy port honest if
   // the width relationship is ever reworked.
   if (occ_width(DEPTH) > ADDR_WIDTH + 1) begin : g_bad_occ
      $error("linear_layer_start_fifo_srl: occupancy does not fit ADDR_WIDTH+1 bits");
   end

   localparam logic [ADDR_WIDTH:0]   CNT_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH + 1)'(1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   logic [ADDR_WIDTH:0]   cnt_q,     cnt_d;
   logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
   logic                  empty_n_q, empty_n_d;
   logic                  full_n_q,  full_n_d;

   logic push;
   logic pop;

   // Acceptance is qualified only by registered flags.
   assign push = if_write & if_write_ce & full_n_q;
   assign pop  = if_read  & if_read_ce  & empty_n_q;

   // ---------------------------------------------------------------------
   // Next-state
   // ---------------------------------------------------------------------
   always_comb begin
      cnt_d     = cnt_q;
      rd_addr_d = rd_addr_q;

      if (push && !pop) begin
         cnt_d = cnt_q + CNT_ONE;
         // The first token lands in slot 0, which is where rd_addr already
         // points; only later pushes move the head further up.
         if (cnt_q != '0) begin
            rd_addr_d = rd_addr_q + ADDR_ONE;
         end
      end else if (pop && !push) begin
         cnt_d = cnt_q - CNT_ONE;
         // Popping the last token leaves rd_addr parked at 0.
         if (cnt_q != CNT_ONE) begin
            rd_addr_d = rd_addr_q - ADDR_ONE;
         end
      end
      // push & pop together: the shift moves the next-oldest token into the
      // head slot while rd_addr stays put, so nothing changes here.

      empty_n_d = (cnt_d != '0);
      full_n_d  = (cnt_d != CNT_DEPTH);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q     <= '0;
         rd_addr_q <= '0;
         empty_n_q <= EMPTY_N_RST;
         full_n_q  <= FULL_N_RST;
      end else begin
         cnt_q     <= cnt_d;
         rd_addr_q <= rd_addr_d;
         empty_n_q <= empty_n_d;
         full_n_q  <= full_n_d;
      end
   end

   // ---------------------------------------------------------------------
   // Storage
   // ---------------------------------------------------------------------
   linear_layer_start_fifo_srl_shiftreg #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .DEPTH      (DEPTH)
   ) u_shiftreg (
      .clk  (clk),
      .we   (push),
      .addr (rd_addr_q),
      .din  (if_din),
      .dout (if_dout)
   );

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign if_full_n         = full_n_q;
   assign if_empty_n        = empty_n_q;
   assign if_num_data_valid = cnt_q;

endmodule : linear_layer_start_fifo_srl

// File: tb/tb_linear_layer_start_fifo_srl.sv
// -----------------------------------------------------------------------------
// tb_linear_layer_start_fifo_srl
//
// Directed and random traffic against linear_layer_start_fifo_srl with
// DEPTH=4, DATA_WIDTH=8, ADDR_WIDTH=2. The reference is an occupancy count
// plus a queue of tokens in arrival order; a monitor checks flags, the FWFT
// head and every popped token against it.
// -----------------------------------------------------------------------------
module tb_linear_layer_start_fifo_srl;

   localparam int DW    = 8;
   localparam int AW    = 2;
   localparam int DEPTH = 4;

   // ------------------------------------------------------------------
   // Clock / reset
   // ------------------------------------------------------------------
   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          if_write_ce = 1'b0;
   logic          if_write = 1'b0;
   logic [DW-1:0] if_din = '0;
   logic          if_full_n;
   logic          if_read_ce = 1'b0;
   logic          if_read = 1'b0;
   logic [DW-1:0] if_dout;
   logic          if_empty_n;
   logic [AW:0]   if_num_data_valid;

   always #5 clk = ~clk;

   linear_layer_start_fifo_srl #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .DEPTH      (DEPTH)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .if_write_ce       (if_write_ce),
      .if_write          (if_write),
      .if_din            (if_din),
      .if_full_n         (if_full_n),
      .if_read_ce        (if_read_ce),
      .if_read           (if_read),
      .if_dout           (if_dout),
      .if_empty_n        (if_empty_n),
      .if_num_data_valid (if_num_data_valid)
   );

   // ------------------------------------------------------------------
   // Reference model and scoreboard
   // ------------------------------------------------------------------
   logic [DW-1:0] exp_q[$];     // tokens held, oldest first
   int            model_cnt = 0;
   logic          exp_empty_n;
   logic          exp_full_n;
   logic [AW:0]   exp_cnt;
   logic          check_en = 1'b0;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
      end
   endtask

   // Monitor: samples on the falling edge, mid-cycle.
   always @(negedge clk) begin
      if (check_en) begin
         check("empty_n", 32'(if_empty_n), 32'(exp_empty_n));
         check("full_n", 32'(if_full_n), 32'(exp_full_n));
         check("num_data_valid", 32'(if_num_data_valid), 32'(exp_cnt));
         if (exp_empty_n && exp_q.size() > 0) begin
            check("fwft_head", 32'(if_dout), 32'(exp_q[0]));
         end
         if (if_read && if_read_ce && if_empty_n && !reset) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL pop_underflow at %0t: got pop of 0x%0h, expected no token", $time, if_dout);
            end else begin
               check("pop_data", 32'(if_dout), 32'(exp_q.pop_front()));
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Driver: called at posedge+1, returns at the next posedge+1.
   // ------------------------------------------------------------------
   task automatic step(input logic rst, input logic wr, input logic wce,
                       input logic [DW-1:0] d, input logic rd, input logic rce);
      logic acc_push;
      logic acc_pop;
      reset       = rst;
      if_write    = wr;
      if_write_ce = wce;
      if_din      = d;
      if_read     = rd;
      if_read_ce  = rce;

      // What the FIFO must look like during this cycle.
      exp_empty_n = (model_cnt != 0);
      exp_full_n  = (model_cnt != DEPTH);
      exp_cnt     = (AW + 1)'(model_cnt);

      acc_push = !rst && wr && wce && (model_cnt < DEPTH);
      acc_pop  = !rst && rd && rce && (model_cnt > 0);
      if (acc_push) exp_q.push_back(d);

      @(negedge clk);
      #1;
      if (rst) begin
         exp_q.delete();
         model_cnt = 0;
      end else begin
         model_cnt = model_cnt + int'(acc_push) - int'(acc_pop);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, '0, 1'b0, 1'b1);
   endtask

   task automatic wr(input logic [DW-1:0] d);
      step(1'b0, 1'b1, 1'b1, d, 1'b0, 1'b1);
   endtask

   task automatic rd();
      step(1'b0, 1'b0, 1'b1, '0, 1'b1, 1'b1);
   endtask

   task automatic drain();
      for (int i = 0; i < 2 * DEPTH && model_cnt > 0; i++) rd();
   endtask

   // ------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------
   initial begin
      repeat (2) @(posedge clk);
      #1;
      check_en = 1'b1;

      // Reset held one more cycle, then idle: reset-state flags.
      step(1'b1, 1'b0, 1'b1, '0, 1'b0, 1'b1);
      idle(3);

      // Fill back-to-back, then a write against full is dropped.
      wr(8'h11); wr(8'h22); wr(8'h33); wr(8'h44);
      wr(8'h55);
      idle(1);

      // Pop four times from full.
      rd(); rd(); rd(); rd();
      idle(1);

      // Hold two entries, simultaneous write+read for three cycles.
      wr(8'hA1); wr(8'hA2);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 8'hA0 + DW'(i), 1'b1, 1'b1);
      drain();
      idle(1);

      // Empty with write+read: only the write lands.
      step(1'b0, 1'b1, 1'b1, 8'h7E, 1'b1, 1'b1);
      idle(1);
      wr(8'h01); wr(8'h02); wr(8'h03);
      // Full with write+read: only the pop lands.
      step(1'b0, 1'b1, 1'b1, 8'hEE, 1'b1, 1'b1);
      idle(1);
      drain();

      // Fill to three, then reset with a concurrent write.
      wr(8'hC1); wr(8'hC2); wr(8'hC3);
      step(1'b1, 1'b1, 1'b1, 8'hC4, 1'b0, 1'b1);
      idle(2);

      // Read-side CE low freezes pops; write-side CE low freezes pushes.
      wr(8'hD1); wr(8'hD2);
      step(1'b0, 1'b0, 1'b1, '0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1, '0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0, 8'hD3, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b0, 8'hD4, 1'b0, 1'b1);
      drain();

      // Random traffic with occasional mid-stream reset.
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 59) == 0),
              1'($urandom_range(0, 1)),
              ($urandom_range(0, 3) != 0),
              DW'($urandom_range(0, 255)),
              1'($urandom_range(0, 1)),
              ($urandom_range(0, 3) != 0));
      end
      drain();
      idle(2);

      check_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Global time bound.
   initial begin
      #200000;
      $display("FAIL watchdog: got no completion by %0t, expected completion", $time);
      $fatal(1);
   end

endmodule : tb_linear_layer_start_fifo_srl
